// File: rtl/int_ctxt_stack_pkg.sv
// Shared types and helpers for the interrupt-context stack.
package int_stack_pkg;

    // Occupancy state; drives the empty/full flags.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } occ_state_e;

    // Overflow policy selectors for OVF_MODE.
    localparam int OVF_REJECT    = 0;
    localparam int OVF_OVERWRITE = 1;

    // Packed frame width: {ret_addr, ctxt_addr, bit_cnt, pass, mask, C_F}.
    function automatic int frame_w(input int aw, input int dw, input int pw, input int dd);
        return 2 * aw + 2 * dw + pw + dd;
    endfunction

endpackage

// File: rtl/int_ctxt_stack_if.sv
// Push/pop bus between AP_ctrl and the context stack.
interface int_ctxt_stack_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_DEPTH     = 128,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int PASS_WIDTH     = 3,
    parameter int STACK_DEPTH    = 8
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic                      push_req;
    logic                      pop_req;
    logic                      flush;
    logic                      clr_err;
    logic [ADDR_WIDTH_MEM-1:0] ret_addr;
    logic [ADDR_WIDTH_MEM-1:0] ctxt_addr;
    logic [DATA_WIDTH-1:0]     tmp_bit_cnt;
    logic [DATA_WIDTH-1:0]     tmp_mask;
    logic [PASS_WIDTH-1:0]     tmp_pass;
    logic [DATA_DEPTH-1:0]     tmp_C_F;

    logic                      push_ready;
    logic [ADDR_WIDTH_MEM-1:0] ret_addr_ret;
    logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_ret;
    logic [DATA_WIDTH-1:0]     tmp_bit_cnt_ret;
    logic [PASS_WIDTH-1:0]     tmp_pass_ret;
    logic [DATA_WIDTH-1:0]     tmp_mask_ret;
    logic [DATA_DEPTH-1:0]     tmp_C_F_ret;
    logic                      pop_valid;
    logic [CNT_W-1:0]          depth_cnt;
    logic                      empty;
    logic                      full;
    logic                      ovf_err;
    logic                      udf_err;

    modport master (
        output push_req, pop_req, flush, clr_err,
        output ret_addr, ctxt_addr, tmp_bit_cnt, tmp_mask, tmp_pass, tmp_C_F,
        input  push_ready, ret_addr_ret, ctxt_addr_ret, tmp_bit_cnt_ret, tmp_pass_ret,
        input  tmp_mask_ret, tmp_C_F_ret, pop_valid, depth_cnt, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  push_req, pop_req, flush, clr_err,
        input  ret_addr, ctxt_addr, tmp_bit_cnt, tmp_mask, tmp_pass, tmp_C_F,
        output push_ready, ret_addr_ret, ctxt_addr_ret, tmp_bit_cnt_ret, tmp_pass_ret,
        output tmp_mask_ret, tmp_C_F_ret, pop_valid, depth_cnt, empty, full, ovf_err, udf_err
    );

endinterface

// File: rtl/int_ctxt_stack_mem.sv
// Frame register file: one synchronous write port, one asynchronous read port.
module ctxt_frame_mem #(
    parameter int STACK_DEPTH = 8,
    parameter int FRAME_W     = 195,
    localparam int PTR_W      = $clog2(STACK_DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [FRAME_W-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [FRAME_W-1:0] rdata
);
    // Storage is intentionally not reset; occupancy alone defines validity.
    logic [FRAME_W-1:0] mem_q [STACK_DEPTH];

    // Write the selected slot on the rising edge.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/int_ctxt_stack.sv
// Interrupt-context stack: circular buffer of frames with push/pop/swap,
// occupancy tracking, sticky errors and a reject/overwrite overflow policy.
module int_ctxt_stack
    import int_stack_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int DATA_DEPTH     = 128,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int PASS_WIDTH     = 3,
    parameter int STACK_DEPTH    = 8,
    parameter int OVF_MODE       = OVF_REJECT
) (
    input logic            clk,
    input logic            rst,
    int_ctxt_stack_if.slave bus
);
    localparam int FW    = frame_w(ADDR_WIDTH_MEM, DATA_WIDTH, PASS_WIDTH, DATA_DEPTH);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    occ_state_e       state_q, state_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [PTR_W-1:0] bot_q, bot_d;
    logic [FW-1:0]    ret_q, ret_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] next_idx;
    logic [FW-1:0]    frame_in;
    logic [FW-1:0]    top_frame;
    logic             is_empty;
    logic             is_full;

    assign frame_in = {bus.ret_addr, bus.ctxt_addr, bus.tmp_bit_cnt,
                       bus.tmp_pass, bus.tmp_mask, bus.tmp_C_F};

    // A full count truncates to zero in PTR_W bits, so bot+depth wraps back to bot.
    assign next_idx = bot_q + depth_q[PTR_W-1:0];
    assign top_idx  = next_idx - PTR_W'(1);
    assign is_empty = (state_q == S_EMPTY);
    assign is_full  = (state_q == S_FULL);

    ctxt_frame_mem #(
        .STACK_DEPTH (STACK_DEPTH),
        .FRAME_W     (FW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (frame_in),
        .raddr (top_idx),
        .rdata (top_frame)
    );

    // Next-state for pointers, popped frame, errors and occupancy.
    always_comb begin
        depth_d     = depth_q;
        bot_d       = bot_q;
        ret_d       = ret_q;
        pop_valid_d = 1'b0;
        ovf_d       = bus.clr_err ? 1'b0 : ovf_q;
        udf_d       = bus.clr_err ? 1'b0 : udf_q;
        mem_we      = 1'b0;
        mem_waddr   = next_idx;

        if (bus.flush) begin
            depth_d = '0;
            bot_d   = '0;
        end else if (bus.push_req && bus.pop_req) begin
            // Swap (or pass-through when empty): never an error.
            pop_valid_d = 1'b1;
            if (is_empty) begin
                ret_d = frame_in;
            end else begin
                ret_d     = top_frame;
                mem_we    = 1'b1;
                mem_waddr = top_idx;
            end
        end else if (bus.push_req) begin
            if (!is_full) begin
                mem_we  = 1'b1;
                depth_d = depth_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
                if (OVF_MODE == OVF_OVERWRITE) begin
                    // Oldest frame is replaced; the base slides up one slot.
                    mem_we    = 1'b1;
                    mem_waddr = bot_q;
                    bot_d     = bot_q + PTR_W'(1);
                end
            end
        end else if (bus.pop_req) begin
            if (is_empty) begin
                udf_d = 1'b1;
            end else begin
                ret_d       = top_frame;
                pop_valid_d = 1'b1;
                depth_d     = depth_q - CNT_W'(1);
            end
        end

        if (depth_d == '0)                     state_d = S_EMPTY;
        else if (depth_d == CNT_W'(STACK_DEPTH)) state_d = S_FULL;
        else                                   state_d = S_PART;
    end

    // All control state, with synchronous reset dominating everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            depth_q     <= '0;
            bot_q       <= '0;
            ret_q       <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            bot_q       <= bot_d;
            ret_q       <= ret_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign {bus.ret_addr_ret, bus.ctxt_addr_ret, bus.tmp_bit_cnt_ret,
            bus.tmp_pass_ret, bus.tmp_mask_ret, bus.tmp_C_F_ret} = ret_q;

    assign bus.pop_valid  = pop_valid_q;
    assign bus.depth_cnt  = depth_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.ovf_err    = ovf_q;
    assign bus.udf_err    = udf_q;
    assign bus.push_ready = !is_full || (OVF_MODE == OVF_OVERWRITE);

endmodule

// File: tb/tb_int_ctxt_stack.sv
// Bench for int_ctxt_stack: two instances (reject / overwrite policy) driven
// with identical directed stimulus; popped frames are checked by a scoreboard.
module tb_int_ctxt_stack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_ctxt_stack_if if0 ();
    int_ctxt_stack_if if1 ();

    int_ctxt_stack #(.OVF_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    int_ctxt_stack #(.OVF_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks   = 0;
    int failures = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every field of a frame is derived from its return address.
    task automatic drive(input logic push, input logic pop, input logic fl,
                         input logic clr, input logic [15:0] ra);
        if0.push_req = push; if1.push_req = push;
        if0.pop_req = pop;   if1.pop_req = pop;
        if0.flush = fl;      if1.flush = fl;
        if0.clr_err = clr;   if1.clr_err = clr;
        if0.ret_addr = ra;             if1.ret_addr = ra;
        if0.ctxt_addr = ~ra;           if1.ctxt_addr = ~ra;
        if0.tmp_bit_cnt = ra ^ 16'h5A5A; if1.tmp_bit_cnt = ra ^ 16'h5A5A;
        if0.tmp_pass = ra[2:0];        if1.tmp_pass = ra[2:0];
        if0.tmp_mask = ra + 16'd1;     if1.tmp_mask = ra + 16'd1;
        if0.tmp_C_F = {8{ra}};         if1.tmp_C_F = {8{ra}};
    endtask

    task automatic step(input logic push, input logic pop, input logic fl,
                        input logic clr, input logic [15:0] ra);
        drive(push, pop, fl, clr, ra);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic cmp_frame(input string tag, input logic [15:0] ra,
                             input logic [15:0] r, input logic [15:0] c, input logic [15:0] b,
                             input logic [2:0] p, input logic [15:0] m, input logic [127:0] cf);
        chk({tag, ".ret_addr"}, 128'(r), 128'(ra));
        if ((c !== ~ra) || (b !== (ra ^ 16'h5A5A)) || (p !== ra[2:0]) ||
            (m !== ra + 16'd1) || (cf !== {8{ra}}))
            chk({tag, ".fields_ok"}, 128'(0), 128'(1));
    endtask

    // Scoreboard monitors: compare each popped frame against the queued expectation.
    always @(negedge clk) begin
        if (if0.pop_valid) begin
            if (q0.size() == 0) chk("dut0.unexpected_pop_valid", 128'(1), 128'(0));
            else cmp_frame("dut0", q0.pop_front(), if0.ret_addr_ret, if0.ctxt_addr_ret,
                           if0.tmp_bit_cnt_ret, if0.tmp_pass_ret, if0.tmp_mask_ret, if0.tmp_C_F_ret);
        end
    end

    always @(negedge clk) begin
        if (if1.pop_valid) begin
            if (q1.size() == 0) chk("dut1.unexpected_pop_valid", 128'(1), 128'(0));
            else cmp_frame("dut1", q1.pop_front(), if1.ret_addr_ret, if1.ctxt_addr_ret,
                           if1.tmp_bit_cnt_ret, if1.tmp_pass_ret, if1.tmp_mask_ret, if1.tmp_C_F_ret);
        end
    end

    task automatic pop_exp(input logic [15:0] e0, input logic [15:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic chk_occ(input string tag, input int d, input logic e, input logic f);
        chk({tag, ".depth0"}, 128'(if0.depth_cnt), 128'(d));
        chk({tag, ".depth1"}, 128'(if1.depth_cnt), 128'(d));
        chk({tag, ".empty"},  128'({if0.empty, if1.empty}), 128'({e, e}));
        chk({tag, ".full"},   128'({if0.full, if1.full}), 128'({f, f}));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk_occ("reset", 0, 1'b1, 1'b0);
        chk("reset.errs", 128'({if0.ovf_err, if0.udf_err, if1.ovf_err, if1.udf_err}), 128'(0));
        chk("reset.ret", 128'({if0.ret_addr_ret, if0.tmp_C_F_ret}), 128'(0));
        chk("reset.pop_valid", 128'({if0.pop_valid, if1.pop_valid}), 128'(0));
        chk("reset.push_ready", 128'({if0.push_ready, if1.push_ready}), 128'(2'b11));

        // Underflow on empty pop: no pop_valid, ret stays 0
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("udf.err", 128'({if0.udf_err, if1.udf_err}), 128'(2'b11));
        chk("udf.pop_valid", 128'({if0.pop_valid, if1.pop_valid}), 128'(0));
        chk("udf.ret", 128'(if0.ret_addr_ret), 128'(0));
        chk_occ("udf", 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("clr.udf", 128'({if0.udf_err, if1.udf_err}), 128'(0));

        // Fill to full, then drain LIFO
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i));
        chk_occ("fill", 8, 1'b0, 1'b1);
        chk("fill.push_ready", 128'({if0.push_ready, if1.push_ready}), 128'(2'b01));
        for (int i = 7; i >= 0; i--) pop_exp(16'h0100 + 16'(i), 16'h0100 + 16'(i));
        chk_occ("drain", 0, 1'b1, 1'b0);
        chk("drain.udf", 128'({if0.udf_err, if1.udf_err}), 128'(0));

        // Overflow: reject keeps 0x10..0x17, overwrite keeps 0x12..0x19
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010 + 16'(i));
        chk("ovf9.err", 128'({if0.ovf_err, if1.ovf_err}), 128'(2'b11));
        chk_occ("ovf9", 8, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0019);
        chk_occ("ovf10", 8, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) pop_exp(16'h0017 - 16'(i), 16'h0019 - 16'(i));
        chk_occ("ovf.drain", 0, 1'b1, 1'b0);
        chk("ovf.sticky", 128'({if0.ovf_err, if1.ovf_err}), 128'(2'b11));
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("clr.ovf", 128'({if0.ovf_err, if1.ovf_err}), 128'(0));

        // Swap at depth 3
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h000A);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h000B);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h000C);
        q0.push_back(16'h000C); q1.push_back(16'h000C);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h000D);
        chk_occ("swap", 3, 1'b0, 1'b0);
        chk("swap.errs", 128'({if0.ovf_err, if0.udf_err, if1.ovf_err, if1.udf_err}), 128'(0));
        pop_exp(16'h000D, 16'h000D);
        pop_exp(16'h000B, 16'h000B);
        pop_exp(16'h000A, 16'h000A);

        // Pass-through on empty
        q0.push_back(16'h0055); q1.push_back(16'h0055);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0055);
        chk("pass.pop_valid", 128'({if0.pop_valid, if1.pop_valid}), 128'(2'b11));
        chk_occ("pass", 0, 1'b1, 1'b0);
        chk("pass.udf", 128'({if0.udf_err, if1.udf_err}), 128'(0));

        // Flush at depth 5 ignores push/pop and keeps errors
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0060 + 16'(i));
        chk_occ("pre_flush", 5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0066);
        chk_occ("flush", 0, 1'b1, 1'b0);
        chk("flush.pop_valid", 128'({if0.pop_valid, if1.pop_valid}), 128'(0));
        chk("flush.keeps_udf", 128'({if0.udf_err, if1.udf_err}), 128'(2'b11));

        // Clear and new error in same cycle: set wins
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
        chk("clr_vs_set.udf", 128'({if0.udf_err, if1.udf_err}), 128'(2'b11));

        // Reset mid-push
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0070);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0071);
        chk_occ("pre_rst", 2, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0072);
        rst = 1'b0;
        chk_occ("rst_mid", 0, 1'b1, 1'b0);
        chk("rst_mid.ret", 128'({if0.ret_addr_ret, if1.ret_addr_ret}), 128'(0));
        chk("rst_mid.errs", 128'({if0.ovf_err, if0.udf_err, if1.ovf_err, if1.udf_err}), 128'(0));
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("rst_mid.udf", 128'({if0.udf_err, if1.udf_err}), 128'(2'b11));
        chk("rst_mid.no_pop", 128'({if0.pop_valid, if1.pop_valid}), 128'(0));

        @(negedge clk);
        chk("scoreboard.drained", 128'(q0.size() + q1.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
